// File: rtl/seven_seg_pkg.sv
// Shared seven-segment definitions: segment patterns {G,F,E,D,C,B,A} active-high,
// scan-decoder state encoding and segment bus width.
package seven_seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_HEX_0 = 7'h3F;
  localparam logic [SEG_W-1:0] SEG_HEX_1 = 7'h06;
  localparam logic [SEG_W-1:0] SEG_HEX_2 = 7'h5B;
  localparam logic [SEG_W-1:0] SEG_HEX_3 = 7'h4F;
  localparam logic [SEG_W-1:0] SEG_HEX_4 = 7'h66;
  localparam logic [SEG_W-1:0] SEG_HEX_5 = 7'h6D;
  localparam logic [SEG_W-1:0] SEG_HEX_6 = 7'h7D;
  localparam logic [SEG_W-1:0] SEG_HEX_7 = 7'h07;
  localparam logic [SEG_W-1:0] SEG_HEX_8 = 7'h7F;
  localparam logic [SEG_W-1:0] SEG_HEX_9 = 7'h67;
  localparam logic [SEG_W-1:0] SEG_HEX_A = 7'h77;
  localparam logic [SEG_W-1:0] SEG_HEX_B = 7'h7C;
  localparam logic [SEG_W-1:0] SEG_HEX_C = 7'h39;
  localparam logic [SEG_W-1:0] SEG_HEX_D = 7'h5E;
  localparam logic [SEG_W-1:0] SEG_HEX_E = 7'h79;
  localparam logic [SEG_W-1:0] SEG_HEX_F = 7'h71;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } scan_state_e;

endpackage

// File: rtl/seven_seg_pattern_decode.sv
// Inverse of the hex-to-segment encoder: maps a 7-bit pattern back to a nibble.
// Patterns outside the table decode to 0 with invalid set.
module seven_seg_pattern_decode
  import seven_seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       value,
  output logic             invalid
);

  always_comb begin
    value   = 4'h0;
    invalid = 1'b0;
    case (pattern)
      SEG_HEX_0: value = 4'h0;
      SEG_HEX_1: value = 4'h1;
      SEG_HEX_2: value = 4'h2;
      SEG_HEX_3: value = 4'h3;
      SEG_HEX_4: value = 4'h4;
      SEG_HEX_5: value = 4'h5;
      SEG_HEX_6: value = 4'h6;
      SEG_HEX_7: value = 4'h7;
      SEG_HEX_8: value = 4'h8;
      SEG_HEX_9: value = 4'h9;
      SEG_HEX_A: value = 4'hA;
      SEG_HEX_B: value = 4'hB;
      SEG_HEX_C: value = 4'hC;
      SEG_HEX_D: value = 4'hD;
      SEG_HEX_E: value = 4'hE;
      SEG_HEX_F: value = 4'hF;
      default:   invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Snoops a multiplexed seven-segment bus, debounces each digit slot and assembles
// decoded digits into frames. Define SEVEN_SEG_DP_EN to also capture the DP segment.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
`ifdef SEVEN_SEG_DP_EN
  input  logic                    dp_in,
  output logic                    upd_dp,
  output logic [NUM_DIGITS-1:0]   frame_dp,
`endif
  output logic                    upd_valid,
  output logic [2:0]              upd_digit,
  output logic [3:0]              upd_value,
  output logic                    upd_invalid,
  output logic                    ghost_err,
  output logic                    frame_valid,
  input  logic                    frame_ready,
  output logic [4*NUM_DIGITS-1:0] frame_data,
  output logic [NUM_DIGITS-1:0]   frame_invalid,
  output logic                    overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
`ifdef SEVEN_SEG_DP_EN
  localparam int SW = NUM_DIGITS + SEG_W + 1;
`else
  localparam int SW = NUM_DIGITS + SEG_W;
`endif

  logic [SEG_W-1:0]            seg_m, seg_s;
  logic [NUM_DIGITS-1:0]       dig_m, dig_s;
  logic [SW-1:0]               s, prev_s;
  logic [CNT_W-1:0]            stab_cnt, stab_nxt;
  logic                        changed, settled, onehot, capture, complete;
  logic [2:0]                  idx;
  logic [3:0]                  dec_value;
  logic                        dec_invalid;
  logic [NUM_DIGITS-1:0][3:0]  digits;
  logic [NUM_DIGITS-1:0]       inv_r, seen, seen_nxt;
  scan_state_e                 state;

`ifdef SEVEN_SEG_DP_EN
  logic                        dp_m, dp_s;
  logic [NUM_DIGITS-1:0]       dp_r;
  assign s = {dp_s, dig_s, seg_s};
`else
  assign s = {dig_s, seg_s};
`endif

  seven_seg_pattern_decode u_dec (
    .pattern (seg_s),
    .value   (dec_value),
    .invalid (dec_invalid)
  );

  // Settled is judged on the count this edge will store, so capture lands
  // exactly STABLE_CYCLES clocks after the synchronized sample changes.
  always_comb begin
    changed = (s != prev_s);
    if (changed)
      stab_nxt = CNT_W'(1);
    else if (stab_cnt == CNT_W'(STABLE_CYCLES))
      stab_nxt = stab_cnt;
    else
      stab_nxt = stab_cnt + CNT_W'(1);
    settled = !changed && (stab_nxt == CNT_W'(STABLE_CYCLES));
  end

  always_comb begin
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (dig_s[i]) idx = 3'(i);
    onehot   = (dig_s != '0) && ((dig_s & (dig_s - NUM_DIGITS'(1))) == '0);
    capture  = (state == SETTLE) && settled && onehot;
    complete = &seen;
    seen_nxt = complete ? '0 : seen;
    if (capture) seen_nxt = seen_nxt | dig_s;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_m         <= '0;
      seg_s         <= '0;
      dig_m         <= '0;
      dig_s         <= '0;
      prev_s        <= '0;
      stab_cnt      <= '0;
      state         <= IDLE;
      digits        <= '0;
      inv_r         <= '0;
      seen          <= '0;
      upd_valid     <= 1'b0;
      upd_digit     <= '0;
      upd_value     <= '0;
      upd_invalid   <= 1'b0;
      ghost_err     <= 1'b0;
      frame_valid   <= 1'b0;
      frame_data    <= '0;
      frame_invalid <= '0;
      overrun       <= 1'b0;
`ifdef SEVEN_SEG_DP_EN
      dp_m          <= 1'b0;
      dp_s          <= 1'b0;
      dp_r          <= '0;
      upd_dp        <= 1'b0;
      frame_dp      <= '0;
`endif
    end else begin
      seg_m     <= seg_in;
      seg_s     <= seg_m;
      dig_m     <= dig_en;
      dig_s     <= dig_m;
`ifdef SEVEN_SEG_DP_EN
      dp_m      <= dp_in;
      dp_s      <= dp_m;
`endif
      prev_s    <= s;
      stab_cnt  <= stab_nxt;
      upd_valid <= 1'b0;
      ghost_err <= 1'b0;
      seen      <= seen_nxt;

      if (frame_valid && frame_ready) frame_valid <= 1'b0;
      // A frame completing while the previous one is still pending is dropped.
      if (complete) begin
        if (!frame_valid || frame_ready) begin
          frame_valid   <= 1'b1;
          frame_data    <= digits;
          frame_invalid <= inv_r;
`ifdef SEVEN_SEG_DP_EN
          frame_dp      <= dp_r;
`endif
        end else begin
          overrun <= 1'b1;
        end
      end

      if (capture) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (dig_s[i]) begin
            digits[i] <= dec_value;
            inv_r[i]  <= dec_invalid;
`ifdef SEVEN_SEG_DP_EN
            dp_r[i]   <= dp_s;
`endif
          end
        end
        upd_valid   <= 1'b1;
        upd_digit   <= idx;
        upd_value   <= dec_value;
        upd_invalid <= dec_invalid;
`ifdef SEVEN_SEG_DP_EN
        upd_dp      <= dp_s;
`endif
      end

      case (state)
        IDLE:
          if (dig_s != '0) state <= SETTLE;
        SETTLE:
          if (changed)
            state <= (dig_s != '0) ? SETTLE : IDLE;
          else if (settled) begin
            if (onehot)
              state <= HOLD;
            else if (dig_s != '0) begin
              ghost_err <= 1'b1;
              state     <= HOLD;
            end else
              state <= IDLE;
          end
        HOLD:
          if (changed) state <= (dig_s != '0) ? SETTLE : IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Scoreboard bench for seven_seg_scan_decoder: stimulus queues expected digit
// updates and frames, negedge monitors pop and compare.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  dig_en = '0;
  logic        frame_ready = 1'b0;
  logic        upd_valid, upd_invalid, ghost_err, frame_valid, overrun;
  logic [2:0]  upd_digit;
  logic [3:0]  upd_value, frame_invalid;
  logic [15:0] frame_data;
`ifdef SEVEN_SEG_DP_EN
  logic        dp_in = 1'b0;
  logic        upd_dp;
  logic [3:0]  frame_dp;
`endif

  seven_seg_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .seg_in        (seg_in),
    .dig_en        (dig_en),
`ifdef SEVEN_SEG_DP_EN
    .dp_in         (dp_in),
    .upd_dp        (upd_dp),
    .frame_dp      (frame_dp),
`endif
    .upd_valid     (upd_valid),
    .upd_digit     (upd_digit),
    .upd_value     (upd_value),
    .upd_invalid   (upd_invalid),
    .ghost_err     (ghost_err),
    .frame_valid   (frame_valid),
    .frame_ready   (frame_ready),
    .frame_data    (frame_data),
    .frame_invalid (frame_invalid),
    .overrun       (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] digit; logic [3:0] value; logic inv;} upd_t;
  typedef struct packed {logic [15:0] data; logic [3:0] inv;} frm_t;

  upd_t upd_q[$];
  frm_t frm_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ghost_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, between DUT updates.
  logic        prev_fv = 1'b0, prev_acc = 1'b0;
  logic [15:0] prev_fd = '0;
  always @(negedge clk) begin
    upd_t ue;
    frm_t fe;
    if (!rst_n) begin
      prev_fv  <= 1'b0;
      prev_acc <= 1'b0;
    end else begin
      if (upd_valid) begin
        if (upd_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL upd_unexpected digit=%0d value=%0h expected=no_update", upd_digit, upd_value);
        end else begin
          ue = upd_q.pop_front();
          chk("upd_digit", 32'(upd_digit), 32'(ue.digit));
          chk("upd_value", 32'(upd_value), 32'(ue.value));
          chk("upd_invalid", 32'(upd_invalid), 32'(ue.inv));
        end
      end
      if (ghost_err) ghost_cnt++;
      if (frame_valid && prev_fv && !prev_acc)
        chk("frame_stable", 32'(frame_data), 32'(prev_fd));
      if (frame_valid && frame_ready) begin
        if (frm_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL frame_unexpected data=%0h expected=no_frame", frame_data);
        end else begin
          fe = frm_q.pop_front();
          chk("frame_data", 32'(frame_data), 32'(fe.data));
          chk("frame_invalid", 32'(frame_invalid), 32'(fe.inv));
        end
      end
      prev_fv  <= frame_valid;
      prev_acc <= frame_valid && frame_ready;
      prev_fd  <= frame_data;
    end
  end

  // Called at posedge+1; returns at posedge+1 after n clocks.
  task automatic drive(input logic [3:0] d, input logic [6:0] s, input int n);
    dig_en = d;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic slot(input int i, input logic [6:0] s, input logic [3:0] v, input logic inv);
    upd_q.push_back('{digit: 3'(i), value: v, inv: inv});
    drive(4'(1 << i), s, 8);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_upd_valid"}, 32'(upd_valid), 0);
    chk({tag, "_upd_fields"}, {upd_digit, upd_value, upd_invalid}, 0);
    chk({tag, "_ghost"}, 32'(ghost_err), 0);
    chk({tag, "_frame_valid"}, 32'(frame_valid), 0);
    chk({tag, "_frame_data"}, 32'(frame_data), 0);
    chk({tag, "_frame_invalid"}, 32'(frame_invalid), 0);
    chk({tag, "_overrun"}, 32'(overrun), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int g0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single digit capture and latency
    upd_q.push_back('{digit: 3'd0, value: 4'h0, inv: 1'b0});
    dig_en = 4'b0001;
    seg_in = 7'h3F;
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (upd_valid) break;
    end
    chk("latency", 32'(n), 6);
    @(posedge clk);
    #1;
    drive(4'b0001, 7'h3F, 3);

    // Full scan, consumer ready
    frame_ready = 1'b1;
    frm_q.push_back('{data: 16'hF921, inv: 4'h0});
    slot(0, 7'h06, 4'h1, 1'b0);
    slot(1, 7'h5B, 4'h2, 1'b0);
    slot(2, 7'h67, 4'h9, 1'b0);
    slot(3, 7'h71, 4'hF, 1'b0);
    drive(4'b1000, 7'h71, 4);
    chk("frame1_delivered", 32'(frm_q.size()), 0);

    // Bouncing segments never settle; then an invalid pattern settles
    repeat (3) begin
      drive(4'b0010, 7'h06, 2);
      drive(4'b0010, 7'h5B, 2);
    end
    chk("bounce_no_capture", 32'({upd_digit, upd_value}), 32'({3'd3, 4'hF}));
    slot(1, 7'h2A, 4'h0, 1'b1);
    chk("invalid_value", 32'(upd_value), 0);
    chk("invalid_flag", 32'(upd_invalid), 1);

    // Ghosting: two enables held stable
    g0 = ghost_cnt;
    drive(4'b0011, 7'h06, 10);
    chk("ghost_pulses", 32'(ghost_cnt - g0), 1);
    drive(4'b0000, 7'h00, 4);

    // Two frames with consumer stalled: second dropped
    frame_ready = 1'b0;
    frm_q.push_back('{data: 16'h4321, inv: 4'h0});
    slot(0, 7'h06, 4'h1, 1'b0);
    slot(1, 7'h5B, 4'h2, 1'b0);
    slot(2, 7'h4F, 4'h3, 1'b0);
    slot(3, 7'h66, 4'h4, 1'b0);
    slot(0, 7'h7D, 4'h6, 1'b0);
    slot(1, 7'h07, 4'h7, 1'b0);
    slot(2, 7'h7F, 4'h8, 1'b0);
    slot(3, 7'h67, 4'h9, 1'b0);
    drive(4'b1000, 7'h67, 2);
    chk("overrun_set", 32'(overrun), 1);
    chk("stalled_valid", 32'(frame_valid), 1);
    chk("kept_first_frame", 32'(frame_data), 32'h4321);
    frame_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("valid_drops", 32'(frame_valid), 0);
    chk("overrun_sticky", 32'(overrun), 1);
    chk("frame2_delivered", 32'(frm_q.size()), 0);
    @(posedge clk);
    #1;

    // Reset mid-frame discards partial captures
    slot(0, 7'h3F, 4'h0, 1'b0);
    slot(1, 7'h06, 4'h1, 1'b0);
    rst_n = 1'b0;
    dig_en = '0;
    seg_in = '0;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midreset");
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    slot(2, 7'h77, 4'hA, 1'b0);
    slot(3, 7'h7C, 4'hB, 1'b0);
    drive(4'b1000, 7'h7C, 4);
    chk("no_frame_after_reset", 32'(frame_valid), 0);
    frm_q.push_back('{data: 16'hBADC, inv: 4'h0});
    slot(0, 7'h39, 4'hC, 1'b0);
    slot(1, 7'h5E, 4'hD, 1'b0);
    drive(4'b0010, 7'h5E, 4);
    chk("frame3_delivered", 32'(frm_q.size()), 0);
    chk("upd_all_seen", 32'(upd_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_decoder.md
Name: seven_seg_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-segment encoder.
- Samples an externally driven, multiplexed seven-segment display bus (one-hot digit enables plus segment lines), debounces each digit slot, and inverse-decodes segment patterns back to 4-bit hex.
- Assembles a full scan into one frame word, delivered on a valid/ready handshake.
- Used for board self-test and for snooping a display driven by a peripheral.

Parameters:
- NUM_DIGITS, 4: digit slots on the bus (2..8).
- STABLE_CYCLES, 4: consecutive identical synchronized samples required before capture (>=2).
- CNT_W, $clog2(STABLE_CYCLES+1): local width, not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- seg_in  in  7  segments {G,F,E,D,C,B,A}, active-high, asynchronous source
- dig_en  in  NUM_DIGITS  digit enables, active-high, one-hot when driven, asynchronous source
- upd_valid  out  1  one-cycle pulse: a digit was captured
- upd_digit  out  3  index of captured digit
- upd_value  out  4  decoded hex value
- upd_invalid  out  1  captured pattern not in table
- ghost_err  out  1  one-cycle pulse: more than one dig_en bit held stable
- frame_valid  out  1  frame register holds an unaccepted frame
- frame_ready  in  1  consumer accepts the frame
- frame_data  out  4*NUM_DIGITS  digit i at bits [4i+3:4i]
- frame_invalid  out  NUM_DIGITS  per-digit invalid flags for the frame
- overrun  out  1  sticky: a frame was dropped

Behaviour:
- Reset: on a clk edge with rst_n=0, all outputs, sync flops, counters, seen mask and digit registers go to 0, and state goes to IDLE. Reset mid-frame discards partial captures.
- Input sync: 2-flop synchronizer on seg_in and dig_en. The resulting sample s = {dig_en_s, seg_s}.
- Stability counter:
  - If s differs from the previous s, stab_cnt = 1.
  - Otherwise stab_cnt increments, saturating at STABLE_CYCLES.
- State machine:
  - IDLE: waits for dig_en_s != 0, then goes to SETTLE.
  - SETTLE, when stab_cnt reaches STABLE_CYCLES:
    - dig_en_s one-hot: capture, then go to HOLD.
    - More than one bit set: pulse ghost_err, then go to HOLD.
    - dig_en_s == 0: go to IDLE.
  - SETTLE or HOLD, on any change of s: if dig_en_s != 0 go to SETTLE, else go to IDLE.
  - HOLD produces no repeat capture while the sample is unchanged.
- Latency: from an input change to the upd_valid pulse is 2 (sync) + STABLE_CYCLES clocks.
- Decode table (pattern to value), active-high: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 67→9, 77→A, 7C→B, 39→C, 5E→D, 79→E, 71→F.
  - 9 has no D segment.
  - Any other pattern, including 00, gives value 0 and invalid=1.
- Capture:
  - Writes digit register [idx] and invalid bit [idx], and sets seen[idx].
  - Pulses upd_valid for 1 cycle, with upd_digit/upd_value/upd_invalid registered alongside it.
  - The upd_* fields hold until the next capture.
- Frame completion:
  - Occurs in the cycle after the capture that makes seen all ones.
  - Copies the digit registers into frame_data/frame_invalid, sets frame_valid, and clears seen.
  - Recapturing an already-seen digit overwrites its register without affecting completion.
- Handshake:
  - frame_valid && frame_ready completes the transfer, and frame_valid drops next cycle.
  - frame_data is stable while frame_valid=1.
- Completion while frame_valid=1 and frame_ready=0: the new frame is dropped, frame registers are unchanged, and overrun is set. overrun stays set until reset.
- Completion in the same cycle as an accepting handshake: the new frame loads, frame_valid stays 1, and there is no overrun.

Optional Feature:
- SEVEN_SEG_DP_EN defined:
  - Adds input dp_in (1, synchronized and included in s) and outputs upd_dp (1) and frame_dp (NUM_DIGITS).
  - The DP bit is captured per digit and does not affect decode validity.
- Undefined: no DP ports exist, and the DP segment is ignored.

Decomposition:
- Package seven_seg_pkg holds:
  - the 16 SEG_HEX_x 7-bit pattern constants, shared with the encoder;
  - the state enum typedef (IDLE, SETTLE, HOLD);
  - SEG_W=7.
- One combinational sub-module, seven_seg_pattern_decode: 7-bit pattern in, 4-bit value plus invalid out, table-driven from the package.
- Synchronizer, counter, FSM and frame logic stay in the top module.

Test Plan:
- Drive dig_en=0001, seg=3F for 10 clocks → upd_valid pulse 6 clocks after the change; digit 0, value 0, invalid 0.
- Scan 4 digits with seg 06/5B/67/71, 8 clocks each, frame_ready=1 → frame_valid with frame_data=16'hF921 (digit 3 = F at [15:12]), frame_invalid=0000.
- seg toggling every 2 clocks on digit 1 with STABLE_CYCLES=4 → no upd_valid; then hold 2A... (invalid pattern) stable → upd_value=0, upd_invalid=1.
- dig_en=0011 held 10 clocks → single ghost_err pulse, no capture, seen unchanged.
- Complete two frames with frame_ready=0 → second frame dropped, overrun=1, frame_data keeps the first frame; assert frame_ready → frame_valid drops next cycle, overrun stays 1.
- rst_n=0 for 1 clock after 2 digits captured → all outputs 0; the next frame needs all 4 digits recaptured.
